// File: rtl/core2axi4l_pipe_pkg.sv
// Shared types for the core-to-AXI4-Lite pipelined bridge.
//   resp_t : AXI response encodings
//   prot_t : AxPROT field
//   mode_e : bridge direction mode (IDLE / READ / WRITE)
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef logic [2:0] prot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } mode_e;

endpackage

// File: rtl/core2axi4l_pipe_if.sv
// Bus bundle for core2axi4l_pipe: core req/gnt/rvalid side, the five
// AXI4-Lite channels and the error-capture sideband.
//   master : bridge view (drives gnt/rvalid and AXI valids/payload)
//   slave  : environment view (core requester plus AXI subordinate)
interface core2axi4l_pipe_if
  import axi4l_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  localparam int StrbW = DataWidth / 8;

  // core side
  logic                 core_req;
  logic                 core_gnt;
  logic                 core_we;
  logic [AddrWidth-1:0] core_addr;
  logic [StrbW-1:0]     core_be;
  logic [DataWidth-1:0] core_wdata;
  logic                 core_rvalid;
  logic [DataWidth-1:0] core_rdata;
  logic                 core_err;
  // AXI4-Lite
  logic                 axi_awvalid, axi_awready;
  logic [AddrWidth-1:0] axi_awaddr;
  prot_t                axi_awprot;
  logic                 axi_wvalid, axi_wready;
  logic [DataWidth-1:0] axi_wdata;
  logic [StrbW-1:0]     axi_wstrb;
  logic                 axi_bvalid, axi_bready;
  logic [1:0]           axi_bresp;
  logic                 axi_arvalid, axi_arready;
  logic [AddrWidth-1:0] axi_araddr;
  prot_t                axi_arprot;
  logic                 axi_rvalid, axi_rready;
  logic [DataWidth-1:0] axi_rdata;
  logic [1:0]           axi_rresp;
  // error capture
  logic                 err_valid;
  logic [AddrWidth-1:0] err_addr;
  logic                 err_clr;

  modport master (
    input  core_req, core_we, core_addr, core_be, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_err,
    output axi_awvalid, axi_awaddr, axi_awprot, input axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, input axi_wready,
    input  axi_bvalid, axi_bresp, output axi_bready,
    output axi_arvalid, axi_araddr, axi_arprot, input axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp, output axi_rready,
    output err_valid, err_addr, input err_clr
  );

  modport slave (
    output core_req, core_we, core_addr, core_be, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_err,
    input  axi_awvalid, axi_awaddr, axi_awprot, output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, output axi_wready,
    output axi_bvalid, axi_bresp, input axi_bready,
    input  axi_arvalid, axi_araddr, axi_arprot, output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp, input axi_rready,
    input  err_valid, err_addr, output err_clr
  );

endinterface

// File: rtl/axi4l_addr_fifo.sv
// Small synchronous FIFO holding addresses of in-flight transactions.
//   push_i/data_i : write side; a push while full is accepted only
//                   together with a pop
//   pop_i/data_o  : read side; data_o shows the head (first-word fall-through)
//   empty_o/full_o: status
module axi4l_addr_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/core2axi4l_pipe.sv
// Pipelined core req/gnt/rvalid -> AXI4-Lite master bridge.
// Up to MaxOutstanding transactions of one direction in flight, responses
// returned to the core in order one cycle after the AXI B/R handshake.
//   clk, rst_n : clock, async active-low reset
//   bus        : core2axi4l_pipe_if.master (core side, AXI channels,
//                err_valid/err_addr/err_clr)
// Optional: define CORE2AXI4L_PIPE_ERRCAP_EN to capture the address of the
// first errored transaction; otherwise err_valid/err_addr are tied to 0.
module core2axi4l_pipe
  import axi4l_pkg::*;
#(
  parameter int    AddrWidth      = 32,
  parameter int    DataWidth      = 32,
  parameter int    MaxOutstanding = 4,
  parameter prot_t AxProt         = 3'b000
) (
  input logic clk,
  input logic rst_n,
  core2axi4l_pipe_if.master bus
);
  localparam int StrbW = DataWidth / 8;
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  // issue slot
  logic                 slot_vld_q, slot_vld_d;
  logic                 slot_we_q, slot_we_d;
  logic [AddrWidth-1:0] slot_addr_q, slot_addr_d;
  logic [StrbW-1:0]     slot_be_q, slot_be_d;
  logic [DataWidth-1:0] slot_wdata_q, slot_wdata_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  // bookkeeping
  mode_e                mode_q, mode_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // core response
  logic                 rsp_vld_q;
  logic                 rsp_err_q, rsp_err_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

  logic aw_hs, w_hs, ar_hs, slot_done;
  logic b_ok, r_ok, rsp_hs, rsp_err;
  logic cnt_ok, mode_ok, gnt;

  assign bus.axi_awvalid = slot_vld_q & slot_we_q & ~aw_done_q;
  assign bus.axi_wvalid  = slot_vld_q & slot_we_q & ~w_done_q;
  assign bus.axi_arvalid = slot_vld_q & ~slot_we_q;
  assign bus.axi_awaddr  = slot_addr_q;
  assign bus.axi_araddr  = slot_addr_q;
  assign bus.axi_wdata   = slot_wdata_q;
  assign bus.axi_wstrb   = slot_be_q;
  assign bus.axi_awprot  = AxProt;
  assign bus.axi_arprot  = AxProt;
  assign bus.axi_bready  = 1'b1;
  assign bus.axi_rready  = 1'b1;

  assign aw_hs = bus.axi_awvalid & bus.axi_awready;
  assign w_hs  = bus.axi_wvalid & bus.axi_wready;
  assign ar_hs = bus.axi_arvalid & bus.axi_arready;

  // A write slot finishes once both halves are done, whichever came first.
  assign slot_done = slot_vld_q & (slot_we_q ? ((aw_done_q | aw_hs) & (w_done_q | w_hs))
                                             : ar_hs);

  // Only responses matching the current direction and with something in
  // flight are counted; anything else is a stray and is dropped.
  assign b_ok    = bus.axi_bvalid & (mode_q == WRITE) & (cnt_q != '0);
  assign r_ok    = bus.axi_rvalid & (mode_q == READ) & (cnt_q != '0);
  assign rsp_hs  = b_ok | r_ok;
  assign rsp_err = b_ok ? bus.axi_bresp[1] : bus.axi_rresp[1];

  assign cnt_ok = (cnt_q < MaxCnt) | rsp_hs;

  always_comb begin
    mode_ok = 1'b1;
    case (mode_q)
      READ:    mode_ok = ~bus.core_we;
      WRITE:   mode_ok = bus.core_we;
      default: mode_ok = 1'b1;
    endcase
  end

  assign gnt          = bus.core_req & (~slot_vld_q | slot_done) & cnt_ok & mode_ok;
  assign bus.core_gnt = gnt;

  // Mode FSM. cnt_q == 0 implies the slot is empty, since every slot
  // occupant was counted at grant time.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      IDLE:        if (gnt) mode_d = bus.core_we ? WRITE : READ;
      READ, WRITE: if ((cnt_q == '0) && !gnt) mode_d = IDLE;
      default:     mode_d = IDLE;
    endcase
  end

  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_be_d    = slot_be_q;
    slot_wdata_d = slot_wdata_q;
    aw_done_d    = aw_done_q | aw_hs;
    w_done_d     = w_done_q | w_hs;
    if (gnt) begin
      slot_vld_d   = 1'b1;
      slot_we_d    = bus.core_we;
      slot_addr_d  = bus.core_addr;
      slot_be_d    = bus.core_be;
      slot_wdata_d = bus.core_wdata;
      aw_done_d    = 1'b0;
      w_done_d     = 1'b0;
    end else if (slot_done) begin
      slot_vld_d = 1'b0;
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // core_rdata holds its last value between responses; core_err is a pulse.
  assign rsp_err_d   = rsp_hs & rsp_err;
  assign rsp_rdata_d = rsp_hs ? (r_ok ? bus.axi_rdata : '0) : rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q   <= 1'b0;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_be_q    <= '0;
      slot_wdata_q <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      mode_q       <= IDLE;
      cnt_q        <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      slot_vld_q   <= slot_vld_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_be_q    <= slot_be_d;
      slot_wdata_q <= slot_wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      rsp_vld_q    <= rsp_hs;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign bus.core_rvalid = rsp_vld_q;
  assign bus.core_err    = rsp_err_q;
  assign bus.core_rdata  = rsp_rdata_q;

`ifdef CORE2AXI4L_PIPE_ERRCAP_EN
  // FIFO order matches response order, so the head is the address of the
  // transaction being answered.
  logic [AddrWidth-1:0] head_addr;
  logic                 fifo_empty, fifo_full;
  logic                 unused_fifo_flags;
  logic                 err_valid_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic                 err_cap;

  axi4l_addr_fifo #(
    .Width (AddrWidth),
    .Depth (MaxOutstanding)
  ) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (gnt),
    .data_i  (bus.core_addr),
    .pop_i   (rsp_hs),
    .data_o  (head_addr),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign unused_fifo_flags = fifo_empty | fifo_full;

  // A clear arriving with a new error loses to the new capture.
  assign err_cap = rsp_hs & rsp_err & (~err_valid_q | bus.err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (err_cap) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= head_addr;
    end else if (bus.err_clr) begin
      err_valid_q <= 1'b0;
    end
  end

  assign bus.err_valid = err_valid_q;
  assign bus.err_addr  = err_addr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_valid  = 1'b0;
  assign bus.err_addr   = '0;
`endif

endmodule

// File: tb/tb_core2axi4l_pipe.sv
// Directed bench for core2axi4l_pipe: reset values, single read, write
// burst against MaxOutstanding, split AW/W handshakes, direction switch,
// reset with reads in flight, error capture.
module tb_core2axi4l_pipe;
  import axi4l_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  core2axi4l_pipe_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  core2axi4l_pipe #(
    .AddrWidth      (32),
    .DataWidth      (32),
    .MaxOutstanding (4),
    .AxProt         (3'b000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef CORE2AXI4L_PIPE_ERRCAP_EN
  localparam logic        ErrCap   = 1'b1;
  localparam logic [31:0] ErrAddrX = 32'h2004;
`else
  localparam logic        ErrCap   = 1'b0;
  localparam logic [31:0] ErrAddrX = 32'h0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.core_req   = r;
    bus.core_we    = we;
    bus.core_addr  = a;
    bus.core_be    = 4'hF;
    bus.core_wdata = d;
  endtask

  initial begin
    req(0, 0, 0, 0);
    bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_arready = 0;
    bus.axi_bvalid = 0; bus.axi_bresp = OKAY;
    bus.axi_rvalid = 0; bus.axi_rresp = OKAY; bus.axi_rdata = 0;
    bus.err_clr = 0;

    // ---- reset values
    tick(); tick();
    chk("rst_awvalid", bus.axi_awvalid, 0);
    chk("rst_wvalid", bus.axi_wvalid, 0);
    chk("rst_arvalid", bus.axi_arvalid, 0);
    chk("rst_rvalid", bus.core_rvalid, 0);
    chk("rst_rdata", bus.core_rdata, 0);
    chk("rst_err", bus.core_err, 0);
    chk("rst_err_valid", bus.err_valid, 0);
    chk("rst_err_addr", bus.err_addr, 0);
    chk("rst_readies", {bus.axi_bready, bus.axi_rready}, 2'b11);
    rst_n = 1;

    // ---- single read 0x1000
    req(1, 0, 32'h1000, 0); #1;
    chk("rd_gnt_c0", bus.core_gnt, 1);
    tick(); req(0, 0, 0, 0);
    chk("rd_arvalid_c1", bus.axi_arvalid, 1);
    chk("rd_araddr_c1", bus.axi_araddr, 32'h1000);
    chk("rd_arprot", bus.axi_arprot, 3'b000);
    tick(); bus.axi_arready = 1;
    chk("rd_arvalid_c2", bus.axi_arvalid, 1);
    tick(); bus.axi_arready = 0;
    chk("rd_arvalid_c3", bus.axi_arvalid, 0);
    tick(); bus.axi_rvalid = 1; bus.axi_rdata = 32'hDEADBEEF; bus.axi_rresp = OKAY;
    chk("rd_rvalid_c4", bus.core_rvalid, 0);
    tick(); bus.axi_rvalid = 0;
    chk("rd_rvalid_c5", bus.core_rvalid, 1);
    chk("rd_rdata_c5", bus.core_rdata, 32'hDEADBEEF);
    chk("rd_err_c5", bus.core_err, 0);
    tick();
    chk("rd_rvalid_c6", bus.core_rvalid, 0);
    chk("rd_rdata_hold", bus.core_rdata, 32'hDEADBEEF);

    // ---- four writes, B withheld, fifth stalls
    tick();
    bus.axi_awready = 1; bus.axi_wready = 1;
    for (int i = 0; i < 4; i++) begin
      req(1, 1, 32'h100 + 4 * i, 32'hA0 + i); #1;
      chk($sformatf("wr_gnt%0d", i), bus.core_gnt, 1);
      tick();
    end
    req(1, 1, 32'h200, 32'hB5); #1;
    chk("wr_5th_stall_a", bus.core_gnt, 0);
    chk("wr_last_awaddr", bus.axi_awaddr, 32'h10C);
    chk("wr_last_wdata", bus.axi_wdata, 32'hA3);
    tick();
    chk("wr_5th_stall_b", bus.core_gnt, 0);
    tick(); bus.axi_bvalid = 1; bus.axi_bresp = OKAY; #1;
    chk("wr_5th_gnt_on_b", bus.core_gnt, 1);
    tick(); req(0, 0, 0, 0); bus.axi_bresp = OKAY;
    chk("wr_rsp0_v", bus.core_rvalid, 1);
    chk("wr_rsp0_err", bus.core_err, 0);
    chk("wr_rsp0_rdata0", bus.core_rdata, 0);
    tick(); bus.axi_bresp = SLVERR;
    chk("wr_rsp1_v", bus.core_rvalid, 1);
    chk("wr_rsp1_err", bus.core_err, 0);
    tick(); bus.axi_bresp = OKAY;
    chk("wr_rsp2_v", bus.core_rvalid, 1);
    chk("wr_rsp2_err", bus.core_err, 1);
    tick(); bus.axi_bresp = OKAY;
    chk("wr_rsp3_v", bus.core_rvalid, 1);
    chk("wr_rsp3_err", bus.core_err, 0);
    tick(); bus.axi_bvalid = 0;
    chk("wr_rsp4_v", bus.core_rvalid, 1);
    tick();
    chk("wr_rsp_done", bus.core_rvalid, 0);

    // ---- split AW/W handshakes: W at c1, AW at c3
    tick();
    bus.axi_awready = 0; bus.axi_wready = 0;
    req(1, 1, 32'h300, 32'h11); #1;
    chk("sp_gnt_c0", bus.core_gnt, 1);
    tick(); req(1, 1, 32'h304, 32'h22); bus.axi_wready = 1; #1;
    chk("sp_aw_c1", {bus.axi_awvalid, bus.axi_wvalid}, 2'b11);
    chk("sp_gnt_c1", bus.core_gnt, 0);
    tick(); bus.axi_wready = 0; #1;
    chk("sp_aw_c2", {bus.axi_awvalid, bus.axi_wvalid}, 2'b10);
    chk("sp_gnt_c2", bus.core_gnt, 0);
    tick(); bus.axi_awready = 1; #1;
    chk("sp_gnt_c3", bus.core_gnt, 1);
    tick(); req(0, 0, 0, 0); bus.axi_wready = 1;
    chk("sp_aw_c4", {bus.axi_awvalid, bus.axi_wvalid}, 2'b11);
    chk("sp_awaddr_c4", bus.axi_awaddr, 32'h304);
    chk("sp_wdata_c4", bus.axi_wdata, 32'h22);
    tick(); bus.axi_awready = 0; bus.axi_wready = 0;
    chk("sp_aw_c5", {bus.axi_awvalid, bus.axi_wvalid}, 2'b00);
    bus.axi_bvalid = 1; bus.axi_bresp = OKAY;
    tick();
    chk("sp_rsp0", bus.core_rvalid, 1);
    tick(); bus.axi_bvalid = 0;
    chk("sp_rsp1", bus.core_rvalid, 1);
    tick(); bus.axi_bvalid = 1;   // stray B with nothing outstanding
    chk("sp_idle", bus.core_rvalid, 0);
    tick(); bus.axi_bvalid = 0;
    chk("sp_stray_b_dropped", bus.core_rvalid, 0);

    // ---- read outstanding blocks a write
    tick();
    bus.axi_arready = 1;
    req(1, 0, 32'h400, 0); #1;
    chk("dir_rd_gnt", bus.core_gnt, 1);
    tick(); req(1, 1, 32'h500, 32'h55); #1;
    chk("dir_wr_stall_c1", bus.core_gnt, 0);
    tick();
    chk("dir_wr_stall_c2", bus.core_gnt, 0);
    chk("dir_no_aw_c2", bus.axi_awvalid, 0);
    tick(); bus.axi_rvalid = 1; bus.axi_rdata = 32'h1234; bus.axi_rresp = OKAY; #1;
    chk("dir_wr_stall_c3", bus.core_gnt, 0);
    tick(); bus.axi_rvalid = 0; #1;
    chk("dir_wr_stall_c4", bus.core_gnt, 0);
    chk("dir_rd_rsp", bus.core_rdata, 32'h1234);
    tick();
    chk("dir_wr_gnt_c5", bus.core_gnt, 1);
    chk("dir_no_aw_c5", bus.axi_awvalid, 0);
    tick(); req(0, 0, 0, 0); bus.axi_awready = 1; bus.axi_wready = 1;
    chk("dir_awvalid_c6", bus.axi_awvalid, 1);
    chk("dir_awaddr_c6", bus.axi_awaddr, 32'h500);
    tick(); bus.axi_bvalid = 1; bus.axi_bresp = OKAY;
    tick(); bus.axi_bvalid = 0;
    chk("dir_wr_rsp", {bus.core_rvalid, bus.core_err}, 2'b10);
    chk("dir_wr_rdata0", bus.core_rdata, 0);

    // ---- reset with two reads in flight, late R beats dropped
    tick();
    req(1, 0, 32'h600, 0); #1;
    chk("rr_gnt0", bus.core_gnt, 1);
    tick(); req(1, 0, 32'h604, 0); #1;
    chk("rr_gnt1", bus.core_gnt, 1);
    tick(); req(0, 0, 0, 0);
    rst_n = 0; #1;
    chk("rr_rst_arvalid", bus.axi_arvalid, 0);
    chk("rr_rst_rdata", bus.core_rdata, 0);
    tick(); rst_n = 1;
    tick(); bus.axi_rvalid = 1; bus.axi_rdata = 32'hAA;
    tick();
    chk("rr_late_r0", bus.core_rvalid, 0);
    tick(); bus.axi_rvalid = 0;
    chk("rr_late_r1", bus.core_rvalid, 0);
    tick();
    chk("rr_late_rdata", bus.core_rdata, 0);
    req(1, 0, 32'h700, 0); #1;
    chk("rr_post_gnt", bus.core_gnt, 1);
    tick(); req(0, 0, 0, 0);
    chk("rr_post_araddr", bus.axi_araddr, 32'h700);
    tick(); bus.axi_rvalid = 1; bus.axi_rdata = 32'h77;
    tick(); bus.axi_rvalid = 0;
    chk("rr_post_rsp", {bus.core_rvalid, bus.core_rdata}, {1'b1, 32'h77});

    // ---- error capture (tied off without the feature)
    tick(); tick();
    req(1, 0, 32'h2004, 0); #1;
    chk("ec_gnt0", bus.core_gnt, 1);
    tick(); req(1, 0, 32'h2008, 0); #1;
    chk("ec_gnt1", bus.core_gnt, 1);
    tick(); req(0, 0, 0, 0);
    bus.axi_rvalid = 1; bus.axi_rresp = DECERR; bus.axi_rdata = 32'h0;
    tick(); bus.axi_rresp = SLVERR;
    chk("ec_rsp0_err", {bus.core_rvalid, bus.core_err}, 2'b11);
    tick(); bus.axi_rvalid = 0;
    chk("ec_rsp1_err", {bus.core_rvalid, bus.core_err}, 2'b11);
    chk("ec_err_valid", bus.err_valid, ErrCap);
    chk("ec_err_addr", bus.err_addr, ErrAddrX);
    tick(); bus.err_clr = 1;
    chk("ec_err_valid_pre_clr", bus.err_valid, ErrCap);
    tick(); bus.err_clr = 0;
    chk("ec_err_valid_clr", bus.err_valid, 0);
    chk("ec_err_quiet", bus.core_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
